nbit_logic_arbiter: RTL and testbench
=====================================

Name: nbit_logic_arbiter

Overview:
- Shares one n-bit bitwise logic unit (AND/OR/XOR/NOR) between two requesters.
- Requesters use valid/ready handshakes. Arbitration is round-robin.
- Each operation is registered through the FSM and presented on a single response channel, tagged with the requester id.
- Sits between the register-file read stage and writeback in the lab ALU datapath.

Parameters:
- N, 8, operand/result width in bits (N ≥ 1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  2  00 AND, 01 OR, 10 XOR, 11 NOR
- req0_a / req0_b  in  N  operands
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same widths and meanings, requester 1
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_data  out  N  result
- resp_id  out  1  requester that issued the result
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset: one clock; reset is synchronous and active-low (clk, rst_n). While rst_n=0 at a rising edge:
  - state←IDLE, prio←0.
  - resp_valid, resp_data, resp_id, busy all ←0.
  - Operand/op registers ←0.
  - Any in-flight operation is dropped silently.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant rule: if exactly one valid, grant it. If both valid, grant requester `prio`.
  - reqX_ready is combinational, =1 only in IDLE for the granted requester. At most one ready is high per cycle.
  - On grant: latch op/a/b and the granted id; go to EXEC. No valid → stay.
- EXEC:
  - Compute the bitwise op on the latched operands; register it into resp_data and resp_id.
  - resp_valid←1; go to RESP.
- RESP:
  - Hold resp_valid, resp_data and resp_id stable while resp_ready=0.
  - When resp_ready=1: resp_valid←0, prio←~resp_id, go to IDLE.
  - resp_data keeps its last value after the handshake.
- Timing:
  - Latency: accept edge at cycle T → resp_valid high from T+2.
  - Peak throughput: one op per 3 cycles.
  - No new request is accepted while busy=1.
- busy = (state≠IDLE).
- Arithmetic: purely bitwise, width N, no carry or overflow.
- Requester rules:
  - A requester holds valid/op/operands stable until ready.
  - Deasserting valid before ready is legal; the request is simply not granted.
- Illegal states: any unreachable state encoding → IDLE.

Optional Feature:
- Macro NBIT_ARB_ZERO_FLAG_EN.
- Defined: adds output resp_zero (1 bit), registered in EXEC as (result==0). It follows the same hold, reset (0) and stability rules as resp_data.
- Undefined: port absent; no zero-detect logic.

Decomposition:
- Package nbit_arb_pkg holds:
  - op encodings: OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOR=2'b11
  - FSM state encodings: IDLE, EXEC, RESP
- One sub-module, nbit_logic_unit (parameter N): combinational and built from per-bit gate primitives in a generate loop, with a 4:1 op select.
- The arbiter instantiates it once on the latched operands.

Test Plan:
- req0 only, op 00, a=0xF0, b=0x3C, resp_ready=1:
  - req0_ready high in the accept cycle.
  - resp_valid at accept+2 with resp_data=0x30, resp_id=0.
  - busy low again the cycle after the handshake.
- Both valid straight after reset:
  - req0 OR 0x0F|0xA0; req1 XOR 0xFF^0x0F.
  - Responses 0xAF/id0 first, then 0xF0/id1.
  - req1_ready never high while busy.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP.
  - resp_valid, resp_data and resp_id stay stable.
  - No reqX_ready asserted.
  - Completes on the first cycle resp_ready=1.
- Edge operations:
  - NOR 0x00,0x00 → 0xFF.
  - AND 0xAA,0x55 → 0x00, resp_zero=1 when NBIT_ARB_ZERO_FLAG_EN is defined.
  - XOR 0xFF,0xFF → 0x00.
- Reset in EXEC and in RESP: assert rst_n=0 for one edge.
  - Next cycle: resp_valid=0, resp_data=0, busy=0, state IDLE.
  - With both valid afterwards, req0 is granted first.
- Fairness: both requesters held valid continuously for 6 ops, resp_ready=1.
  - resp_id sequence is 0,1,0,1,0,1.

Source files
------------

// File: rtl/nbit_arb_pkg.sv
//==============================================================================
// nbit_arb_pkg : shared encodings for the two-requester logic-unit arbiter.
// Revision     : 1.0
//==============================================================================
`default_nettype none

package nbit_arb_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

`default_nettype wire

// File: rtl/nbit_logic_unit.sv
//==============================================================================
// nbit_logic_unit : combinational N-bit AND/OR/XOR/NOR from per-bit gates.
// Revision        : 1.0
//==============================================================================
`default_nettype none

module nbit_logic_unit
  import nbit_arb_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [1:0]   op_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] y_o
);

  logic [N-1:0] w_and;
  logic [N-1:0] w_or;
  logic [N-1:0] w_xor;
  logic [N-1:0] w_nor;

  for (genvar i = 0; i < N; i++) begin : g_bit
    and u_and (w_and[i], a_i[i], b_i[i]);
    or  u_or  (w_or[i],  a_i[i], b_i[i]);
    xor u_xor (w_xor[i], a_i[i], b_i[i]);
    nor u_nor (w_nor[i], a_i[i], b_i[i]);
  end

  always_comb begin
    y_o = w_and;
    case (op_i)
      OP_AND:  y_o = w_and;
      OP_OR:   y_o = w_or;
      OP_XOR:  y_o = w_xor;
      OP_NOR:  y_o = w_nor;
      default: y_o = w_and;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/nbit_logic_arbiter.sv
//==============================================================================
// nbit_logic_arbiter : round-robin share of one logic unit by two requesters.
// Optional resp_zero output enabled by NBIT_ARB_ZERO_FLAG_EN.   Revision 1.0
//==============================================================================
`default_nettype none

module nbit_logic_arbiter
  import nbit_arb_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [1:0]   req0_op,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [1:0]   req1_op,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [N-1:0] resp_data,
  output logic         resp_id,
`ifdef NBIT_ARB_ZERO_FLAG_EN
  output logic         resp_zero,
`endif
  output logic         busy
);

  state_e       state_q, state_d;
  logic         prio_q;
  logic [1:0]   op_q;
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic         id_q;
  logic         resp_valid_q;
  logic [N-1:0] resp_data_q;
  logic         resp_id_q;
  logic [N-1:0] w_result;

  // prio_q only matters when both requesters are valid at once
  logic w_grant0;
  logic w_grant1;
  assign w_grant0 = req0_valid & (~req1_valid | ~prio_q);
  assign w_grant1 = req1_valid & (~req0_valid |  prio_q);

  nbit_logic_unit #(.N(N)) u_lu (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .y_o  (w_result)
  );

  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = w_grant0;
        req1_ready = w_grant1;
        if (w_grant0 | w_grant1) state_d = EXEC;
      end
      EXEC:    state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      op_q         <= 2'b00;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (w_grant0 | w_grant1) begin
            op_q <= w_grant1 ? req1_op : req0_op;
            a_q  <= w_grant1 ? req1_a  : req0_a;
            b_q  <= w_grant1 ? req1_b  : req0_b;
            id_q <= w_grant1;
          end
        end
        EXEC: begin
          resp_data_q  <= w_result;
          resp_id_q    <= id_q;
          resp_valid_q <= 1'b1;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            prio_q       <= ~resp_id_q;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef NBIT_ARB_ZERO_FLAG_EN
  logic zero_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
    end else if (state_q == EXEC) begin
      zero_q <= (w_result == '0);
    end
  end
  assign resp_zero = zero_q;
`endif

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign busy       = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_nbit_logic_arbiter.sv
//==============================================================================
// tb_nbit_logic_arbiter : directed self-checking bench for nbit_logic_arbiter.
// Revision              : 1.0
//==============================================================================
`default_nettype none

module tb_nbit_logic_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready;
  logic [1:0] req0_op;
  logic [7:0] req0_a, req0_b;
  logic       req1_valid, req1_ready;
  logic [1:0] req1_op;
  logic [7:0] req1_a, req1_b;
  logic       resp_valid, resp_ready;
  logic [7:0] resp_data;
  logic       resp_id;
  logic       busy;
`ifdef NBIT_ARB_ZERO_FLAG_EN
  logic       resp_zero;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  nbit_logic_arbiter #(.N(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
`ifdef NBIT_ARB_ZERO_FLAG_EN
    .resp_zero  (resp_zero),
`endif
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(input string tag, input logic [7:0] exp_data, input logic exp_id);
    int n = 0;
    while (!resp_valid && n < 12) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_data"}, {24'd0, resp_data}, {24'd0, exp_data});
    chk({tag, "_id"}, {31'd0, resp_id}, {31'd0, exp_id});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; resp_ready = 1'b1;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    tick(); tick();
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_data", {24'd0, resp_data}, 32'd0);
    chk("rst_id", {31'd0, resp_id}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;

    // req0 AND F0,3C -> 30
    req0_valid = 1; req0_op = 2'b00; req0_a = 8'hF0; req0_b = 8'h3C;
    #1;
    chk("t1_ready0", {31'd0, req0_ready}, 32'd1);
    chk("t1_ready1", {31'd0, req1_ready}, 32'd0);
    tick(); req0_valid = 0;
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_v_early", {31'd0, resp_valid}, 32'd0);
    tick();
    chk("t1_valid", {31'd0, resp_valid}, 32'd1);
    chk("t1_data", {24'd0, resp_data}, 32'h30);
    chk("t1_id", {31'd0, resp_id}, 32'd0);
    tick();
    chk("t1_busy_after", {31'd0, busy}, 32'd0);
    chk("t1_v_after", {31'd0, resp_valid}, 32'd0);
    chk("t1_data_keep", {24'd0, resp_data}, 32'h30);

    // both valid straight after reset
    do_reset();
    req0_valid = 1; req0_op = 2'b01; req0_a = 8'h0F; req0_b = 8'hA0;
    req1_valid = 1; req1_op = 2'b10; req1_a = 8'hFF; req1_b = 8'h0F;
    #1;
    chk("t2_ready0", {31'd0, req0_ready}, 32'd1);
    chk("t2_ready1", {31'd0, req1_ready}, 32'd0);
    tick(); req0_valid = 0;
    chk("t2_r1_exec", {31'd0, req1_ready}, 32'd0);
    tick();
    chk("t2_r1_resp", {31'd0, req1_ready}, 32'd0);
    chk("t2_data0", {24'd0, resp_data}, 32'hAF);
    chk("t2_id0", {31'd0, resp_id}, 32'd0);
    tick();
    chk("t2_ready1_idle", {31'd0, req1_ready}, 32'd1);
    tick(); req1_valid = 0;
    tick();
    chk("t2_data1", {24'd0, resp_data}, 32'hF0);
    chk("t2_id1", {31'd0, resp_id}, 32'd1);
    tick();

    // backpressure: req1 NOR 00,00 -> FF, held 5 cycles
    resp_ready = 0;
    req1_valid = 1; req1_op = 2'b11; req1_a = 8'h00; req1_b = 8'h00;
    tick(); req1_valid = 0;
    req0_valid = 1; req0_op = 2'b00; req0_a = 8'hAA; req0_b = 8'h55;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_data", {24'd0, resp_data}, 32'hFF);
      chk("bp_id", {31'd0, resp_id}, 32'd1);
      chk("bp_ready0", {31'd0, req0_ready}, 32'd0);
      tick();
    end
    resp_ready = 1;
    tick();
    chk("bp_done", {31'd0, resp_valid}, 32'd0);
    chk("bp_busy", {31'd0, busy}, 32'd0);
    chk("bp_next_ready0", {31'd0, req0_ready}, 32'd1);

    // AND AA,55 -> 00
    tick(); req0_valid = 0;
    wait_resp("and_zero", 8'h00, 1'b0);
`ifdef NBIT_ARB_ZERO_FLAG_EN
    chk("and_zero_flag", {31'd0, resp_zero}, 32'd1);
`endif
    tick();

    // XOR FF,FF -> 00 from req1
    req1_valid = 1; req1_op = 2'b10; req1_a = 8'hFF; req1_b = 8'hFF;
    tick(); req1_valid = 0;
    wait_resp("xor_same", 8'h00, 1'b1);
    tick();

    // reset while in EXEC
    req0_valid = 1; req0_op = 2'b01; req0_a = 8'h01; req0_b = 8'h02;
    tick(); req0_valid = 0;
    chk("rx_in_exec", {31'd0, busy}, 32'd1);
    do_reset();
    chk("rx_valid", {31'd0, resp_valid}, 32'd0);
    chk("rx_busy", {31'd0, busy}, 32'd0);

    // completed req0 op leaves prio at requester 1
    req0_valid = 1; req0_op = 2'b01; req0_a = 8'h0F; req0_b = 8'hA0;
    tick(); req0_valid = 0;
    wait_resp("pre_rr", 8'hAF, 1'b0);
    tick();

    // reset while in RESP with a nonzero result pending
    resp_ready = 0;
    req0_valid = 1; req0_op = 2'b10; req0_a = 8'h0F; req0_b = 8'hFF;
    tick(); req0_valid = 0;
    wait_resp("rr_pend", 8'hF0, 1'b0);
    do_reset();
    resp_ready = 1;
    chk("rr_valid", {31'd0, resp_valid}, 32'd0);
    chk("rr_data", {24'd0, resp_data}, 32'd0);
    chk("rr_busy", {31'd0, busy}, 32'd0);

    // both valid after reset: req0 first; then fairness over 6 ops
    req0_valid = 1; req0_op = 2'b00; req0_a = 8'hF0; req0_b = 8'h3C;
    req1_valid = 1; req1_op = 2'b01; req1_a = 8'h0F; req1_b = 8'hA0;
    #1;
    chk("rr_ready0", {31'd0, req0_ready}, 32'd1);
    chk("rr_ready1", {31'd0, req1_ready}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      wait_resp("fair", (k % 2 == 0) ? 8'h30 : 8'hAF, 1'(k % 2));
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
